idu_stage: RTL
==============

# idu_stage

Pipelined RV32I/RV32E instruction-decode stage. It sits between the fetch unit and the execute unit in the NPC core and replaces the single-instruction, purely combinational decoder. It decodes the full RV32I base opcode map into register indices, a format-correct immediate, an operation class and control flags, and registers the result behind a valid/ready handshake with a one-entry skid buffer.

## Interface
Parameters:
- `XLEN`, 32: data/immediate/PC width; only 32 is supported.
- `NREG`, 32: architectural register count; 32 for RV32I, 16 for RV32E.
- `RAW`, $clog2(NREG): register index width (derived, not overridden).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all held instructions.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  stage accepts an instruction this cycle.
- `in_pc`  in  XLEN  PC of the offered instruction.
- `in_inst`  in  32  raw instruction word.
- `out_valid`  out  1  decoded instruction available.
- `out_ready`  in  1  execute accepts it.
- `out_pc`  out  XLEN  PC, passed through.
- `out_rs1`, `out_rs2`, `out_rd`  out  RAW each  register indices (low RAW bits of the fields).
- `out_imm`  out  XLEN  sign-extended immediate for the I/S/B/U/J format, 0 for R-type.
- `out_op`  out  4  operation class (package enum).
- `out_funct3`  out  3  inst[14:12].
- `out_funct7b5`  out  1  inst[30].
- `out_reg_wen`  out  1  writes rd.
- `out_ebreak`  out  1  instruction is EBREAK (0x00100073).
- `out_illegal`  out  1  illegal instruction.

## Operation
- Op classes: ALU_R, ALU_I, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM, FENCE, ILLEGAL.
- Immediate formats: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}. All are sign-extended from inst[31].
- `out_reg_wen` = 1 for ALU_R, ALU_I, LUI, AUIPC, JAL, JALR and LOAD when rd != 0 and the instruction is not illegal. It is 0 otherwise.
- `out_illegal` is set for any of these cases:
  - unknown opcode;
  - inst[1:0] != 2'b11;
  - a bad funct3/funct7 for OP/OP-IMM/shift/branch/load/store;
  - SYSTEM other than ECALL/EBREAK;
  - (NREG=16) any *used* rs1/rs2/rd field with bit 4 set.
  When `out_illegal` is set, `out_op` = ILLEGAL and `out_reg_wen` = 0.
- Storage:
  - Main output register (M) plus one skid entry (S).
  - `in_ready` = !S.valid, registered; it never depends combinationally on `out_ready`.
- Accept/transfer rules:
  - Input is accepted when `in_valid` && `in_ready`.
  - If M is empty or draining this cycle (`out_ready`), the decoded word goes to M. Otherwise it goes to S.
  - When M drains and S is valid, S moves to M, and S becomes empty unless a new word is accepted into S in the same cycle.
- `flush`:
  - At the next edge, M.valid and S.valid are cleared.
  - An input handshake in the same cycle is dropped.
  - `flush` overrides everything.
- Outputs are stable while `out_valid` && !`out_ready` (AXI-style hold).

## Timing
- Latency: 1 cycle from input handshake to `out_valid`. Throughput is 1 instruction/cycle with `out_ready` held high.
- Reset values (async assert, sync-deasserted externally):
  - `out_valid` = 0 and every payload output = 0.
  - `in_ready` = 1.
  - M and S empty.
- Reset mid-transfer discards both entries with no partial output.
- Full condition: M and S both valid → `in_ready` = 0 from the next cycle. It re-asserts the cycle after M drains.
- Decode is combinational on `in_inst` before the register. There is no path from `out_ready` to `in_ready`.

## Structure
- Package `idu_pkg`: opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM, MISC_MEM), the op-class enum, and a packed decoded-instruction struct used for both M and S.
- Sub-module `idu_decode`: purely combinational inst → struct, parametrised by `NREG`.
- `idu_stage`: handshake, M/S registers, flush.

## Test plan
- `addi x1,x0,5` (0x00500093), out_ready=1 → next cycle: rd=1, rs1=0, imm=5, op=ALU_I, reg_wen=1, illegal=0.
- `lui x2,0x12345` (0x12345137) and `jal x0,-4` (0xFFDFF06F) → imm=0x12345000 with reg_wen=1, then imm=0xFFFFFFFC with reg_wen=0 (rd=0).
- Back-pressure: three back-to-back beats with out_ready=0 for 3 cycles → first beat held stable, second beat in S, in_ready=0, third beat waits. Releasing out_ready delivers all three in order with no loss or duplication.
- EBREAK 0x00100073 → ebreak=1, op=SYSTEM, reg_wen=0. Word 0x00000000 → illegal=1, op=ILLEGAL.
- NREG=16: `addi x17,x0,1` (0x00100893) → illegal=1, reg_wen=0. With NREG=32 the same word decodes legally.
- Flush with M and S full, plus a simultaneous in_valid → next cycle out_valid=0, in_ready=1, and the flushed input never appears. Asserting rst_n low mid-stall gives the same result asynchronously.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared opcodes, op-class enum and decoded-instruction record for the
// RV32I/RV32E decode stage.
package idu_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    OP_ALU_R   = 4'd0,
    OP_ALU_I   = 4'd1,
    OP_LUI     = 4'd2,
    OP_AUIPC   = 4'd3,
    OP_JAL     = 4'd4,
    OP_JALR    = 4'd5,
    OP_BRANCH  = 4'd6,
    OP_LOAD    = 4'd7,
    OP_STORE   = 4'd8,
    OP_SYSTEM  = 4'd9,
    OP_FENCE   = 4'd10,
    OP_ILLEGAL = 4'd11
  } op_class_e;

  // Register fields are kept at full 5-bit width; the stage trims them to RAW.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    op_class_e   op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        reg_wen;
    logic        ebreak;
    logic        illegal;
  } dec_inst_t;

  function automatic logic writes_rd(input op_class_e op);
    return op inside {OP_ALU_R, OP_ALU_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD};
  endfunction

endpackage

// File: rtl/idu_decode.sv
// Purely combinational RV32I/RV32E decoder: raw instruction word to a
// decoded-instruction record.
module idu_decode
  import idu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output dec_inst_t   dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm;
  op_class_e   op;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        bad_fn;
  logic        bad_reg;
  logic        illegal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    op      = OP_ILLEGAL;
    imm     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    bad_fn  = 1'b0;
    case (opcode)
      OPC_OP: begin
        op      = OP_ALU_R;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        // Only SUB and SRA may carry funct7 = 0x20.
        bad_fn  = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        op      = OP_ALU_I;
        imm     = imm_i;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        if (funct3 == 3'b001) begin
          bad_fn = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          bad_fn = !((funct7 == 7'h00) || (funct7 == 7'h20));
        end
      end
      OPC_LUI: begin
        op     = OP_LUI;
        imm    = imm_u;
        use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        op     = OP_AUIPC;
        imm    = imm_u;
        use_rd = 1'b1;
      end
      OPC_JAL: begin
        op     = OP_JAL;
        imm    = imm_j;
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        op      = OP_JALR;
        imm     = imm_i;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        bad_fn  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        op      = OP_BRANCH;
        imm     = imm_b;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_fn  = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        op      = OP_LOAD;
        imm     = imm_i;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        bad_fn  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        op      = OP_STORE;
        imm     = imm_s;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_fn  = funct3[2] || (funct3 == 3'b011);
      end
      OPC_SYSTEM: begin
        op     = OP_SYSTEM;
        imm    = imm_i;
        bad_fn = (inst != INST_ECALL) && (inst != INST_EBREAK);
      end
      OPC_MISC_MEM: begin
        op  = OP_FENCE;
        imm = imm_i;
      end
      default: begin
        bad_fn = 1'b1;
      end
    endcase
  end

  // RV32E only has x0..x15, so bit 4 of any field actually read or written is illegal.
  assign bad_reg = (NREG < 32) &&
                   ((use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11]));
  assign illegal = bad_fn || bad_reg;

  always_comb begin
    dec          = '0;
    dec.pc       = pc;
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = inst[11:7];
    dec.imm      = imm;
    dec.op       = illegal ? OP_ILLEGAL : op;
    dec.funct3   = funct3;
    dec.funct7b5 = inst[30];
    dec.reg_wen  = !illegal && writes_rd(op) && (inst[11:7] != 5'd0);
    dec.ebreak   = (inst == INST_EBREAK);
    dec.illegal  = illegal;
  end

endmodule

// File: rtl/idu_stage.sv
// Pipelined decode stage: combinational decode into a main output register
// backed by a one-entry skid buffer so in_ready never depends on out_ready.
module idu_stage
  import idu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [RAW-1:0]  out_rs1,
  output logic [RAW-1:0]  out_rs2,
  output logic [RAW-1:0]  out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_op,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_reg_wen,
  output logic            out_ebreak,
  output logic            out_illegal
);

  dec_inst_t dec;
  dec_inst_t m_data_d;
  dec_inst_t m_data_q;
  dec_inst_t s_data_d;
  dec_inst_t s_data_q;
  logic      m_valid_d;
  logic      m_valid_q;
  logic      s_valid_d;
  logic      s_valid_q;
  logic      accept;
  logic      m_free;

  idu_decode #(
    .NREG (NREG)
  ) u_decode (
    .pc   (in_pc),
    .inst (in_inst),
    .dec  (dec)
  );

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && !s_valid_q;
  assign m_free   = !m_valid_q || out_ready;

  // The skid entry only fills while M is held, so M refills from S first;
  // S is never valid at the same time as an accept.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = dec;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

  assign out_valid    = m_valid_q;
  assign out_pc       = m_data_q.pc[XLEN-1:0];
  assign out_rs1      = m_data_q.rs1[RAW-1:0];
  assign out_rs2      = m_data_q.rs2[RAW-1:0];
  assign out_rd       = m_data_q.rd[RAW-1:0];
  assign out_imm      = m_data_q.imm[XLEN-1:0];
  assign out_op       = m_data_q.op;
  assign out_funct3   = m_data_q.funct3;
  assign out_funct7b5 = m_data_q.funct7b5;
  assign out_reg_wen  = m_data_q.reg_wen;
  assign out_ebreak   = m_data_q.ebreak;
  assign out_illegal  = m_data_q.illegal;

endmodule
